// File: rtl/apf_wishbone_burst_master.sv
// Request-FIFO-fed Wishbone B4 master: single reads, coalesced incrementing write bursts, err/timeout handling.
// Optional define APF_WB_BYTESWAP_EN adds endian_little and byte reversal of write and read data.
module apf_wishbone_burst_master #(
   parameter int unsigned ADDR_W     = 30,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned MAX_BURST  = 4,
   parameter int unsigned TIMEOUT    = 255
) (
   input  logic                clk_sys,
   input  logic                reset_n,
`ifdef APF_WB_BYTESWAP_EN
   input  logic                endian_little,
`endif
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_we,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_data,
   input  logic [ADDR_W-1:0]   base_addr,
   output logic                rsp_valid,
   output logic [DATA_W-1:0]   rsp_data,
   output logic                rsp_err,
   output logic                wr_err,
   input  logic                wr_err_clr,
   output logic                busy,
   output logic [ADDR_W-1:0]   adr,
   output logic [DATA_W-1:0]   dat_w,
   output logic [DATA_W/8-1:0] sel,
   output logic                cyc,
   output logic                stb,
   output logic                we,
   output logic [2:0]          cti,
   output logic [1:0]          bte,
   input  logic                ack,
   input  logic                err,
   input  logic [DATA_W-1:0]   dat_r
);

   localparam int unsigned SEL_W  = DATA_W / 8;
   localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W  = PTR_W + 1;
   localparam int unsigned BEAT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam int unsigned TMO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   localparam logic [0:0] S_IDLE   = 1'b0;
   localparam logic [0:0] S_ACTIVE = 1'b1;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_INC     = 3'b010;
   localparam logic [2:0] CTI_END     = 3'b111;

   logic              fifo_we   [FIFO_DEPTH];
   logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
   logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];

   logic [PTR_W-1:0]  wr_ptr, rd_ptr, ptr1, ptr2;
   logic [CNT_W-1:0]  count, count_nxt;
   logic              push, pop, fifo_empty;
   logic [DATA_W-1:0] push_data, rx_data;

   logic [0:0]        state, state_nxt;
   logic              cyc_nxt, stb_nxt, we_nxt;
   logic [ADDR_W-1:0] adr_nxt;
   logic [DATA_W-1:0] dat_w_nxt;
   logic [2:0]        cti_nxt;
   logic [BEAT_W-1:0] beat, beat_nxt;
   logic [TMO_W-1:0]  tmo_cnt, tmo_nxt;
   logic              rsp_valid_nxt, rsp_err_nxt, wr_err_set;
   logic [DATA_W-1:0] rsp_data_nxt;
   logic              term, bus_err, tmo_hit, fail;

`ifdef APF_WB_BYTESWAP_EN
   function automatic logic [DATA_W-1:0] byte_rev(input logic [DATA_W-1:0] d);
      logic [DATA_W-1:0] r;
      r = '0;
      for (int i = 0; i < int'(SEL_W); i++) r[8*i +: 8] = d[DATA_W-8-8*i +: 8];
      return r;
   endfunction

   assign push_data = endian_little ? req_data : byte_rev(req_data);
   assign rx_data   = endian_little ? dat_r : byte_rev(dat_r);
`else
   assign push_data = req_data;
   assign rx_data   = dat_r;
`endif

   // Burst continues only into an already-queued sequential write, within the beat limit.
   function automatic logic [2:0] pick_cti(input logic              we_a,
                                           input logic [ADDR_W-1:0] addr_a,
                                           input logic              have_b,
                                           input logic              we_b,
                                           input logic [ADDR_W-1:0] addr_b,
                                           input logic [BEAT_W-1:0] idx);
      if (we_a && have_b && we_b && (addr_b == addr_a + ADDR_W'(1)) &&
          (32'(idx) + 32'd1 < MAX_BURST))
         return CTI_INC;
      else if (idx != '0)
         return CTI_END;
      return CTI_CLASSIC;
   endfunction

   assign sel        = {SEL_W{1'b1}};
   assign bte        = 2'b00;
   assign push       = req_valid && req_ready;
   assign fifo_empty = (count == '0);
   assign ptr1       = rd_ptr + PTR_W'(1);
   assign ptr2       = rd_ptr + PTR_W'(2);

   assign term    = stb && (ack || err);
   assign bus_err = stb && err;
   assign tmo_hit = stb && !ack && !err && (TIMEOUT != 0) && (tmo_cnt == TMO_W'(TIMEOUT - 1));
   assign fail    = bus_err || tmo_hit;

   // Request FIFO storage
   always_ff @(posedge clk_sys) begin
      if (push) begin
         fifo_we[wr_ptr]   <= req_we;
         fifo_addr[wr_ptr] <= req_addr;
         fifo_data[wr_ptr] <= push_data;
      end
   end

   always_comb begin
      count_nxt = count;
      if (push && !pop)
         count_nxt = count + CNT_W'(1);
      else if (!push && pop)
         count_nxt = count - CNT_W'(1);
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         req_ready <= 1'b1;
         busy      <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         count     <= count_nxt;
         req_ready <= (count_nxt != CNT_W'(FIFO_DEPTH));
         busy      <= cyc_nxt || (count_nxt != '0);
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   // Next-state, bus and response decode
   always_comb begin
      state_nxt     = state;
      cyc_nxt       = cyc;
      stb_nxt       = stb;
      we_nxt        = we;
      adr_nxt       = adr;
      dat_w_nxt     = dat_w;
      cti_nxt       = cti;
      beat_nxt      = beat;
      tmo_nxt       = tmo_cnt;
      pop           = 1'b0;
      rsp_valid_nxt = 1'b0;
      rsp_data_nxt  = rsp_data;
      rsp_err_nxt   = rsp_err;
      wr_err_set    = 1'b0;
      case (state)
         S_IDLE: begin
            if (!fifo_empty) begin
               state_nxt = S_ACTIVE;
               cyc_nxt   = 1'b1;
               stb_nxt   = 1'b1;
               we_nxt    = fifo_we[rd_ptr];
               adr_nxt   = fifo_addr[rd_ptr] + base_addr;
               dat_w_nxt = fifo_data[rd_ptr];
               cti_nxt   = pick_cti(fifo_we[rd_ptr], fifo_addr[rd_ptr], count >= CNT_W'(2),
                                    fifo_we[ptr1], fifo_addr[ptr1], '0);
               beat_nxt  = '0;
               tmo_nxt   = '0;
            end
         end
         default: begin
            tmo_nxt = tmo_cnt + TMO_W'(1);
            if (term || tmo_hit) begin
               pop = 1'b1;
               if (!we) begin
                  rsp_valid_nxt = 1'b1;
                  rsp_data_nxt  = rx_data;
                  rsp_err_nxt   = fail;
               end else if (fail) begin
                  wr_err_set = 1'b1;
               end
               if ((cti == CTI_INC) && !fail) begin
                  adr_nxt   = adr + ADDR_W'(1);
                  dat_w_nxt = fifo_data[ptr1];
                  cti_nxt   = pick_cti(fifo_we[ptr1], fifo_addr[ptr1], count >= CNT_W'(3),
                                       fifo_we[ptr2], fifo_addr[ptr2], beat + BEAT_W'(1));
                  beat_nxt  = beat + BEAT_W'(1);
                  tmo_nxt   = '0;
               end else begin
                  state_nxt = S_IDLE;
                  cyc_nxt   = 1'b0;
                  stb_nxt   = 1'b0;
                  we_nxt    = 1'b0;
                  cti_nxt   = CTI_CLASSIC;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         cyc     <= 1'b0;
         stb     <= 1'b0;
         we      <= 1'b0;
         adr     <= '0;
         dat_w   <= '0;
         cti     <= CTI_CLASSIC;
         beat    <= '0;
         tmo_cnt <= '0;
      end else begin
         cyc     <= cyc_nxt;
         stb     <= stb_nxt;
         we      <= we_nxt;
         adr     <= adr_nxt;
         dat_w   <= dat_w_nxt;
         cti     <= cti_nxt;
         beat    <= beat_nxt;
         tmo_cnt <= tmo_nxt;
      end
   end

   // Read response pulse and sticky write error (set beats clear)
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_err   <= 1'b0;
         wr_err    <= 1'b0;
      end else begin
         rsp_valid <= rsp_valid_nxt;
         rsp_data  <= rsp_data_nxt;
         rsp_err   <= rsp_err_nxt;
         wr_err    <= wr_err_set || (wr_err && !wr_err_clr);
      end
   end

endmodule

// File: tb/tb_apf_wishbone_burst_master.sv
// Self-checking bench for apf_wishbone_burst_master: scoreboarded bus beats and read responses.
`timescale 1ns/1ps
module tb_apf_wishbone_burst_master;

   localparam int unsigned AW = 30;
   localparam int unsigned DW = 32;

   typedef struct packed {
      logic [AW-1:0] adr;
      logic          we;
      logic [DW-1:0] dat;
      logic [2:0]    cti;
   } beat_t;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          err;
   } rsp_t;

   logic          clk_sys = 1'b0;
   logic          reset_n;
   logic          req_valid, req_ready, req_we;
   logic [AW-1:0] req_addr, base_addr, adr;
   logic [DW-1:0] req_data, rsp_data, dat_w, dat_r;
   logic          rsp_valid, rsp_err, wr_err, wr_err_clr, busy;
   logic [3:0]    sel;
   logic          cyc, stb, we, ack, err;
   logic [2:0]    cti;
   logic [1:0]    bte;

   beat_t exp_q[$], obs_q[$];
   rsp_t  exp_rsp_q[$], obs_rsp_q[$];
   int    checks = 0;
   int    errors = 0;
   int    ack_delay = 1;
   int    slv_mode = 0;   // 0 ack, 1 err, 2 never respond
   logic [DW-1:0] slv_rdata = '0;
   int    cyc_starts = 0;

   always #5 clk_sys = ~clk_sys;

   apf_wishbone_burst_master #(
      .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(8), .MAX_BURST(4), .TIMEOUT(8)
   ) dut (
      .clk_sys(clk_sys), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_data(req_data), .base_addr(base_addr),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .wr_err(wr_err), .wr_err_clr(wr_err_clr), .busy(busy),
      .adr(adr), .dat_w(dat_w), .sel(sel), .cyc(cyc), .stb(stb), .we(we),
      .cti(cti), .bte(bte), .ack(ack), .err(err), .dat_r(dat_r)
   );

   // Slave responder and monitors, all on the falling edge
   initial begin : slave
      int   wait_cnt;
      logic cyc_prev;
      wait_cnt = 0;
      cyc_prev = 1'b0;
      ack = 1'b0;
      err = 1'b0;
      dat_r = '0;
      forever begin
         @(negedge clk_sys);
         if (reset_n && stb && slv_mode != 2 && wait_cnt >= ack_delay) begin
            ack   = (slv_mode == 0);
            err   = (slv_mode == 1);
            dat_r = slv_rdata;
            obs_q.push_back(beat_t'({adr, we, dat_w, cti}));
            wait_cnt = 0;
         end else begin
            ack = 1'b0;
            err = 1'b0;
            wait_cnt = (reset_n && stb) ? wait_cnt + 1 : 0;
         end
         if (rsp_valid) obs_rsp_q.push_back(rsp_t'({rsp_data, rsp_err}));
         if (cyc && !cyc_prev) cyc_starts++;
         cyc_prev = cyc;
      end
   end

   task automatic push_req(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      int n;
      n = 0;
      @(negedge clk_sys);
      req_valid = 1'b1;
      req_we    = w;
      req_addr  = a;
      req_data  = d;
      while (!req_ready && n < 100) begin
         @(negedge clk_sys);
         n++;
      end
      if (!req_ready) begin
         checks++;
         errors++;
         $display("FAIL push_req ready: got req_ready=%b required 1", req_ready);
      end
   endtask

   task automatic req_idle();
      @(negedge clk_sys);
      req_valid = 1'b0;
   endtask

   task automatic wait_idle(output bit ok);
      int n;
      n = 0;
      do begin
         @(negedge clk_sys);
         n++;
      end while ((busy || cyc) && n < 400);
      ok = !(busy || cyc);
      repeat (2) @(negedge clk_sys);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(negedge clk_sys);
      checks++;
      if ({cyc, stb, we, cti, bte} !== 8'h00) begin
         errors++;
         $display("FAIL reset ctrl: got cyc=%b stb=%b we=%b cti=%b bte=%b required all 0", cyc, stb, we, cti, bte);
      end
      checks++;
      if (adr !== '0 || dat_w !== '0 || sel !== 4'hF) begin
         errors++;
         $display("FAIL reset bus: got adr=%h dat_w=%h sel=%h required 0 0 f", adr, dat_w, sel);
      end
      checks++;
      if ({req_ready, busy, rsp_valid, rsp_err, wr_err} !== 5'b10000 || rsp_data !== '0) begin
         errors++;
         $display("FAIL reset status: got ready=%b busy=%b rsp_valid=%b rsp_err=%b wr_err=%b rsp_data=%h required 1 0 0 0 0 0",
                  req_ready, busy, rsp_valid, rsp_err, wr_err, rsp_data);
      end
      reset_n = 1'b1;
      repeat (3) @(negedge clk_sys);
      checks++;
      if (cyc !== 1'b0 || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset release: got cyc=%b ready=%b required 0 1", cyc, req_ready);
      end
   endtask

   task automatic test_single_write();
      bit ok;
      int s0;
      beat_t e, o;
      ack_delay = 1;
      slv_mode = 0;
      s0 = cyc_starts;
      push_req(1'b1, 30'h10, 32'hDEADBEEF);
      exp_q.push_back(beat_t'{30'h110, 1'b1, 32'hDEADBEEF, 3'b000});
      req_idle();
      checks++;
      if (cyc !== 1'b0) begin
         errors++;
         $display("FAIL single_write latency N+1: got cyc=%b required 0", cyc);
      end
      @(negedge clk_sys);
      checks++;
      if ({cyc, stb, we, cti} !== 6'b111000 || adr !== 30'h110) begin
         errors++;
         $display("FAIL single_write latency N+2: got cyc=%b stb=%b we=%b cti=%b adr=%h required 1 1 1 000 110", cyc, stb, we, cti, adr);
      end
      wait_idle(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL single_write idle: got busy=%b cyc=%b required 0 0", busy, cyc);
      end
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         checks++;
         o = (obs_q.size() != 0) ? obs_q.pop_front() : '0;
         if (o !== e) begin
            errors++;
            $display("FAIL single_write beat: got %h required %h", o, e);
         end
      end
      checks++;
      if (obs_q.size() != 0 || cyc_starts - s0 != 1) begin
         errors++;
         $display("FAIL single_write cycles: got extra=%0d starts=%0d required 0 1", obs_q.size(), cyc_starts - s0);
      end
      obs_q.delete();
   endtask

   task automatic test_read();
      bit ok;
      beat_t e, o;
      rsp_t er, orr;
      ack_delay = 1;
      slv_rdata = 32'h12345678;
      push_req(1'b0, 30'h40, 32'h0);
      exp_q.push_back(beat_t'{30'h140, 1'b0, 32'h0, 3'b000});
      exp_rsp_q.push_back(rsp_t'{32'h12345678, 1'b0});
      req_idle();
      wait_idle(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL read idle: got busy=%b cyc=%b required 0 0", busy, cyc);
      end
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         checks++;
         o = (obs_q.size() != 0) ? obs_q.pop_front() : '0;
         if (o !== e) begin
            errors++;
            $display("FAIL read beat: got %h required %h", o, e);
         end
      end
      while (exp_rsp_q.size() != 0) begin
         er = exp_rsp_q.pop_front();
         checks++;
         orr = (obs_rsp_q.size() != 0) ? obs_rsp_q.pop_front() : '0;
         if (orr !== er) begin
            errors++;
            $display("FAIL read rsp: got data=%h err=%b required data=%h err=%b", orr.data, orr.err, er.data, er.err);
         end
      end
      checks++;
      if (obs_rsp_q.size() != 0) begin
         errors++;
         $display("FAIL read rsp pulse: got %0d extra rsp cycles required 0", obs_rsp_q.size());
      end
      obs_q.delete();
      obs_rsp_q.delete();
   endtask

   // A slow read holds the bus while writes queue up, so the burst decision sees them all
   task automatic test_burst(input int nwr);
      bit ok;
      int s0;
      beat_t e, o;
      ack_delay = 6;
      slv_rdata = 32'hA5A50001;
      s0 = cyc_starts;
      push_req(1'b0, 30'h40, 32'h0);
      exp_q.push_back(beat_t'{30'h140, 1'b0, 32'h0, 3'b000});
      for (int i = 0; i < nwr; i++) begin
         push_req(1'b1, 30'h20 + AW'(i), 32'h10000000 + DW'(i));
         exp_q.push_back(beat_t'{30'h120 + AW'(i), 1'b1, 32'h10000000 + DW'(i),
                                 (i < 3) ? 3'b010 : ((i == 3) ? 3'b111 : 3'b000)});
      end
      req_idle();
      ack_delay = 0;
      wait_idle(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL burst%0d idle: got busy=%b cyc=%b required 0 0", nwr, busy, cyc);
      end
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         checks++;
         o = (obs_q.size() != 0) ? obs_q.pop_front() : '0;
         if (o !== e) begin
            errors++;
            $display("FAIL burst%0d beat: got %h required %h", nwr, o, e);
         end
      end
      checks++;
      if (obs_q.size() != 0 || cyc_starts - s0 != nwr - 2) begin
         errors++;
         $display("FAIL burst%0d cycles: got extra=%0d starts=%0d required 0 %0d", nwr, obs_q.size(), cyc_starts - s0, nwr - 2);
      end
      obs_q.delete();
      obs_rsp_q.delete();
      ack_delay = 1;
   endtask

   task automatic test_timeout();
      bit ok;
      int n, hi;
      beat_t e, o;
      slv_mode = 2;
      push_req(1'b1, 30'h50, 32'hCAFE0001);
      req_idle();
      n = 0;
      while (!stb && n < 20) begin
         @(negedge clk_sys);
         n++;
      end
      hi = 0;
      while (stb && hi < 50) begin
         hi++;
         @(negedge clk_sys);
      end
      checks++;
      if (hi != 8) begin
         errors++;
         $display("FAIL timeout stb width: got %0d cycles required 8", hi);
      end
      checks++;
      if (wr_err !== 1'b1 || cyc !== 1'b0) begin
         errors++;
         $display("FAIL timeout wr_err: got wr_err=%b cyc=%b required 1 0", wr_err, cyc);
      end
      wr_err_clr = 1'b1;
      @(negedge clk_sys);
      wr_err_clr = 1'b0;
      checks++;
      if (wr_err !== 1'b0) begin
         errors++;
         $display("FAIL timeout wr_err_clr: got wr_err=%b required 0", wr_err);
      end
      slv_mode = 0;
      push_req(1'b1, 30'h51, 32'hCAFE0002);
      exp_q.push_back(beat_t'{30'h151, 1'b1, 32'hCAFE0002, 3'b000});
      req_idle();
      wait_idle(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL timeout recovery idle: got busy=%b cyc=%b required 0 0", busy, cyc);
      end
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         checks++;
         o = (obs_q.size() != 0) ? obs_q.pop_front() : '0;
         if (o !== e) begin
            errors++;
            $display("FAIL timeout recovery beat: got %h required %h", o, e);
         end
      end
      obs_q.delete();
   endtask

   task automatic test_bus_err();
      bit ok;
      rsp_t orr;
      slv_mode = 1;
      ack_delay = 1;
      slv_rdata = 32'h0BADF00D;
      push_req(1'b0, 30'h44, 32'h0);
      exp_rsp_q.push_back(rsp_t'{32'h0BADF00D, 1'b1});
      push_req(1'b1, 30'h45, 32'hBAD0BAD0);
      req_idle();
      wait_idle(ok);
      checks++;
      if (!ok || obs_q.size() != 2) begin
         errors++;
         $display("FAIL bus_err beats: got idle=%b beats=%0d required 1 2", ok, obs_q.size());
      end
      checks++;
      orr = (obs_rsp_q.size() != 0) ? obs_rsp_q.pop_front() : '0;
      if (orr !== exp_rsp_q.pop_front()) begin
         errors++;
         $display("FAIL bus_err rsp: got data=%h err=%b required data=0badf00d err=1", orr.data, orr.err);
      end
      checks++;
      if (wr_err !== 1'b1) begin
         errors++;
         $display("FAIL bus_err wr_err: got %b required 1", wr_err);
      end
      wr_err_clr = 1'b1;
      @(negedge clk_sys);
      wr_err_clr = 1'b0;
      slv_mode = 0;
      obs_q.delete();
      obs_rsp_q.delete();
   endtask

   task automatic test_reset_mid_burst();
      int n, s0;
      ack_delay = 6;
      push_req(1'b0, 30'h40, 32'h0);
      for (int i = 0; i < 3; i++) push_req(1'b1, 30'h60 + AW'(i), 32'h60000000 + DW'(i));
      push_req(1'b1, 30'h70, 32'h70000000);
      push_req(1'b1, 30'h71, 32'h70000001);
      req_idle();
      n = 0;
      while (!(cyc && we) && n < 100) begin
         @(negedge clk_sys);
         n++;
      end
      checks++;
      if (!(cyc && we && cti == 3'b010)) begin
         errors++;
         $display("FAIL reset_mid burst start: got cyc=%b we=%b cti=%b required 1 1 010", cyc, we, cti);
      end
      reset_n = 1'b0;
      #1;
      checks++;
      if ({cyc, stb, we, cti} !== 6'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid async: got cyc=%b stb=%b we=%b cti=%b ready=%b busy=%b required 0 0 0 000 1 0",
                  cyc, stb, we, cti, req_ready, busy);
      end
      @(negedge clk_sys);
      @(negedge clk_sys);
      reset_n = 1'b1;
      obs_q.delete();
      obs_rsp_q.delete();
      s0 = cyc_starts;
      repeat (20) @(negedge clk_sys);
      checks++;
      if (cyc_starts != s0 || obs_q.size() != 0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid quiet: got starts=%0d beats=%0d busy=%b required 0 0 0", cyc_starts - s0, obs_q.size(), busy);
      end
      ack_delay = 1;
   endtask

   initial begin
      reset_n    = 1'b0;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_addr   = '0;
      req_data   = '0;
      base_addr  = 30'h100;
      wr_err_clr = 1'b0;
      test_reset();
      test_single_write();
      test_read();
      test_burst(4);
      test_burst(5);
      test_timeout();
      test_bus_err();
      test_reset_mid_burst();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
